obi_mailbox_responder: RTL and testbench
========================================

Name: obi_mailbox_responder

Overview:
- OBI responder (subordinate) on the HEEP clock domain; the mirror of the host-driven OBI initiator bridge.
- The HEEP core acts as OBI initiator. It reads host-supplied instructions from an instruction FIFO and writes results back to a host-side result register.
- It also exposes status and scratch registers.
- Sits on an X-HEEP external slave port; the host side connects to the CW305 register block.

Parameters:
- pINSTR_WIDTH, 32: data width of OBI and host words; fixed at 32.
- pFIFO_DEPTH, 4: instruction FIFO depth; power of two, 2..16.
- pWAIT_CYCLES, 0: extra cycles between grant and rvalid; 0..7.

Ports:
- clk_i  in  1  HEEP clock; sole clock.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  1  OBI request.
- we_i  in  1  OBI write enable.
- be_i  in  4  OBI byte enables.
- addr_i  in  32  OBI byte address; only bits [3:2] decoded.
- wdata_i  in  32  OBI write data.
- gnt_o  out  1  OBI grant.
- rvalid_o  out  1  OBI response valid.
- rdata_o  out  32  OBI read data.
- host_instr_i  in  32  instruction word from host.
- host_instr_valid_i  in  1  host push request.
- host_instr_ready_o  out  1  FIFO not full.
- host_result_o  out  32  result word to host.
- host_result_valid_o  out  1  result held valid.
- host_result_ack_i  in  1  host consumed result (1-cycle pulse).
- underflow_o  out  1  sticky underflow flag.

Behaviour:
Reset (asynchronous, rst_ni low):
- FIFO empty; all pointers and count 0.
- gnt_o=0, rvalid_o=0, rdata_o=0.
- host_result_o=0, host_result_valid_o=0, underflow_o=0, scratch=0.
- FSM forced to IDLE; any in-flight transaction is dropped and no rvalid is issued.
- host_instr_ready_o=1 after reset releases.

Register map (addr_i[3:2]):
- 0 STATUS (RW):
  - Read: bit0 = FIFO not empty; bit1 = host_result_valid_o; bit2 = underflow; bits[8:4] = FIFO count; others 0.
  - Write: if be_i[0] and wdata_i[2] are both 1, clear underflow (W1C). Other bits ignored.
- 1 INSTR (RO, pop-on-read):
  - Read returns the FIFO head and pops it.
  - Read while FIFO empty returns 0, does not pop, and sets underflow.
  - Writes are ignored.
- 2 RESULT (RW):
  - Write loads host_result_o per byte enable and sets host_result_valid_o.
  - Read returns host_result_o.
- 3 SCRATCH (RW): byte-enable writes; read returns the stored value.

FSM states: IDLE, WAIT, RESP.
- IDLE:
  - gnt_o is combinational: req_i AND NOT (we_i AND addr==RESULT AND host_result_valid_o).
  - A RESULT write is therefore back-pressured until the host acks.
  - On grant: the side effect (pop, push, register write, underflow set) commits at that clock edge and rdata is captured.
  - Next state is WAIT if pWAIT_CYCLES>0, else RESP.
- WAIT: counts pWAIT_CYCLES cycles, then moves to RESP. gnt_o=0.
- RESP: rvalid_o=1 for exactly one cycle; rdata_o is valid (0 for writes). Next state IDLE. gnt_o=0.
- One outstanding transaction only.
- Latency: grant to rvalid = 1+pWAIT_CYCLES cycles.
- Back-to-back grants are spaced at minimum 2+pWAIT_CYCLES cycles.
- rdata_o holds its value outside RESP.

FIFO:
- host_instr_ready_o = count<pFIFO_DEPTH.
- Push when host_instr_valid_i and ready are both 1; a push while full is dropped.
- Pointers wrap modulo pFIFO_DEPTH; count width is clog2(pFIFO_DEPTH)+1.
- Simultaneous push and granted INSTR read on a non-empty FIFO: count unchanged; the read returns the old head.
- Simultaneous push and INSTR read on an empty FIFO: read returns 0, underflow set, the pushed word is stored (count=1).
- When full, ready is deasserted even if a pop happens in the same cycle; ready returns the next cycle.

Result:
- host_result_valid_o clears on host_result_ack_i.
- Ack while not valid is ignored.
- Ack in the same cycle as a granted RESULT write cannot occur, because gnt_o is blocked while valid.

Underflow:
- Set dominates clear when both occur in the same cycle; the clear path is a STATUS write, which cannot coincide with an INSTR read.
- underflow_o mirrors the flag.

Test Plan:
1. Reset, push 0xDEADBEEF and 0x00000013, read INSTR twice, read STATUS:
   - rdata 0xDEADBEEF then 0x00000013.
   - STATUS=0x00000000.
   - With pWAIT_CYCLES=0, rvalid comes 1 cycle after each gnt.
2. Push 4 words with depth 4:
   - host_instr_ready_o=0 and a 5th push is dropped.
   - STATUS bits[8:4]=4.
   - 4 INSTR reads return the words in order; a 5th read returns 0 and sets underflow_o=1.
3. Write STATUS with wdata 0x4, be 0x1:
   - underflow_o=0 the next cycle; rvalid pulses with rdata 0.
4. Write RESULT 0x12345678 (be 0xF), then issue a second RESULT write before ack:
   - host_result_o=0x12345678, valid=1.
   - The second write's gnt_o stays 0 until an ack pulse, then it is granted the cycle after valid clears.
5. Write SCRATCH 0xAABBCCDD with be 0xF, then 0x00000011 with be 0x1, then read:
   - rdata 0xAABBCC11.
6. With pWAIT_CYCLES=3, assert rst_ni low during WAIT:
   - All outputs 0 immediately; no rvalid after release.
   - A new read is granted normally, with rvalid 4 cycles after gnt.

Source files
------------

// File: rtl/obi_mailbox_responder.sv
// OBI responder that exposes a host-fed instruction FIFO, a host-side result
// register, a status register and a scratch register to the HEEP core.
// Only one transaction is outstanding at a time. Its response arrives
// 1 + pWAIT_CYCLES cycles after the grant.
module obi_mailbox_responder #(
    parameter int unsigned pINSTR_WIDTH = 32,
    parameter int unsigned pFIFO_DEPTH  = 4,
    parameter int unsigned pWAIT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // OBI subordinate port
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [31:0]             addr_i,
    input  logic [pINSTR_WIDTH-1:0] wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [pINSTR_WIDTH-1:0] rdata_o,
    // host side
    input  logic [pINSTR_WIDTH-1:0] host_instr_i,
    input  logic                    host_instr_valid_i,
    output logic                    host_instr_ready_o,
    output logic [pINSTR_WIDTH-1:0] host_result_o,
    output logic                    host_result_valid_o,
    input  logic                    host_result_ack_i,
    output logic                    underflow_o
);

    localparam int unsigned PTR_W = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(pFIFO_DEPTH);
    localparam logic [2:0] WAIT_LAST = (pWAIT_CYCLES == 0) ? 3'd0 : 3'(pWAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] A_STATUS  = 2'd0;
    localparam logic [1:0] A_INSTR   = 2'd1;
    localparam logic [1:0] A_RESULT  = 2'd2;
    localparam logic [1:0] A_SCRATCH = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [2:0]              wcnt_q, wcnt_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [pINSTR_WIDTH-1:0] mem_q [pFIFO_DEPTH];
    logic [pINSTR_WIDTH-1:0] result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    underflow_q, underflow_d;
    logic [pINSTR_WIDTH-1:0] scratch_q, scratch_d;
    logic [pINSTR_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0]              addr_sel;
    logic                    gnt;
    logic                    wr_gnt;
    logic                    rd_instr;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    uflow_set;
    logic                    uflow_clr;
    logic [pINSTR_WIDTH-1:0] status_word;
    logic [pINSTR_WIDTH-1:0] read_word;
    logic                    unused_addr_bits;

    assign addr_sel         = addr_i[3:2];
    assign unused_addr_bits = ^{addr_i[31:4], addr_i[1:0]};

    // merge new bytes into an old word under byte enables
    function automatic logic [pINSTR_WIDTH-1:0] be_merge(
        input logic [pINSTR_WIDTH-1:0] old_w,
        input logic [pINSTR_WIDTH-1:0] new_w,
        input logic [3:0]              be
    );
        logic [pINSTR_WIDTH-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

    // A RESULT write is held off while the host still owns the previous
    // result. Grant and ready are both forced low while in reset.
    assign gnt = rst_ni && (state_q == ST_IDLE) && req_i &&
                 !(we_i && (addr_sel == A_RESULT) && result_valid_q);
    assign wr_gnt     = gnt && we_i;
    assign rd_instr   = gnt && !we_i && (addr_sel == A_INSTR);
    assign fifo_empty = (count_q == '0);
    assign pop        = rd_instr && !fifo_empty;
    assign uflow_set  = rd_instr && fifo_empty;
    assign uflow_clr  = wr_gnt && (addr_sel == A_STATUS) && be_i[0] && wdata_i[2];

    assign host_instr_ready_o = rst_ni && (count_q < DEPTH_C);
    assign push               = host_instr_valid_i && host_instr_ready_o;

    assign gnt_o               = gnt;
    assign rvalid_o            = (state_q == ST_RESP);
    assign rdata_o             = rdata_q;
    assign host_result_o       = result_q;
    assign host_result_valid_o = result_valid_q;
    assign underflow_o         = underflow_q;

    // read data mux; INSTR on an empty FIFO reads as zero
    always_comb begin
        status_word              = '0;
        status_word[0]           = !fifo_empty;
        status_word[1]           = result_valid_q;
        status_word[2]           = underflow_q;
        status_word[4 +: CNT_W]  = count_q;
        read_word = '0;
        case (addr_sel)
            A_STATUS:  read_word = status_word;
            A_INSTR:   read_word = fifo_empty ? '0 : mem_q[rptr_q];
            A_RESULT:  read_word = result_q;
            A_SCRATCH: read_word = scratch_q;
            default:   read_word = '0;
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // register side effects committed on the grant edge
    always_comb begin
        result_d       = result_q;
        result_valid_d = result_valid_q;
        scratch_d      = scratch_q;
        underflow_d    = underflow_q;
        rdata_d        = rdata_q;
        if (wr_gnt && (addr_sel == A_RESULT)) begin
            result_d       = be_merge(result_q, wdata_i, be_i);
            result_valid_d = 1'b1;
        end else if (host_result_ack_i) begin
            result_valid_d = 1'b0;
        end
        if (wr_gnt && (addr_sel == A_SCRATCH)) begin
            scratch_d = be_merge(scratch_q, wdata_i, be_i);
        end
        // set wins over clear
        if (uflow_set) begin
            underflow_d = 1'b1;
        end else if (uflow_clr) begin
            underflow_d = 1'b0;
        end
        if (gnt) begin
            rdata_d = we_i ? '0 : read_word;
        end
    end

    // transaction sequencing: IDLE -> (WAIT) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    wcnt_d  = '0;
                    state_d = (pWAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // control and register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            underflow_q    <= 1'b0;
            scratch_q      <= '0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            underflow_q    <= underflow_d;
            scratch_q      <= scratch_d;
            rdata_q        <= rdata_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= host_instr_i;
        end
    end

endmodule

// File: tb/tb_obi_mailbox_responder.sv
// Directed bench for obi_mailbox_responder: one instance with no wait
// states, and one with three wait states used for the reset-during-WAIT case.
module tb_obi_mailbox_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0, rst3 = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0, hinstr = '0;
    logic        hvalid = 1'b0, hack = 1'b0;

    logic        gnt0, rvalid0, hready0, hresv0, uf0;
    logic [31:0] rdata0, hres0;
    logic        gnt3, rvalid3, hready3, hresv3, uf3;
    logic [31:0] rdata3, hres3;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    obi_mailbox_responder #(.pINSTR_WIDTH(32), .pFIFO_DEPTH(4), .pWAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst0), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0),
        .host_instr_i(hinstr), .host_instr_valid_i(hvalid), .host_instr_ready_o(hready0),
        .host_result_o(hres0), .host_result_valid_o(hresv0), .host_result_ack_i(hack),
        .underflow_o(uf0));

    obi_mailbox_responder #(.pINSTR_WIDTH(32), .pFIFO_DEPTH(4), .pWAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst3), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .host_instr_i(hinstr), .host_instr_valid_i(hvalid), .host_instr_ready_o(hready3),
        .host_result_o(hres3), .host_result_valid_o(hresv3), .host_result_ack_i(hack),
        .underflow_o(uf3));

    // one OBI transaction on the selected instance, optional same-cycle push
    task automatic xfer(input bit sel, input logic w, input logic [1:0] a, input logic [3:0] b,
                        input logic [31:0] d, input bit do_push, input logic [31:0] pw,
                        output logic [31:0] rd, output int lat, output bit ok);
        int n;
        int m;
        ok = 1'b0; rd = '0; lat = 0; n = 0; m = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = {28'h0, a, 2'b00}; be = b; wdata = d;
        if (do_push) begin hinstr = pw; hvalid = 1'b1; end
        #1;
        while (!(sel ? gnt3 : gnt0) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; hvalid = 1'b0;
        if (n >= 50) return;
        while (m < 50) begin
            @(negedge clk); lat++;
            if (sel ? rvalid3 : rvalid0) begin
                rd = sel ? rdata3 : rdata0; ok = 1'b1; break;
            end
            m++;
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk); hinstr = w; hvalid = 1'b1;
        @(posedge clk); #1 hvalid = 1'b0;
    endtask

    task automatic ack_pulse;
        @(negedge clk); hack = 1'b1;
        @(posedge clk); #1 hack = 1'b0;
    endtask

    task automatic test_reset;
        req = 1'b1; we = 1'b0; addr = 32'h0;
        #12;
        total_cnt++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt: got %b want 0", gnt0); else pass_cnt++;
        total_cnt++; if (rvalid0 !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", rvalid0); else pass_cnt++;
        total_cnt++; if (rdata0 !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata0); else pass_cnt++;
        total_cnt++; if ({hres0, hresv0, uf0} !== 34'h0) $display("FAIL rst_host: got %h/%b/%b want 0", hres0, hresv0, uf0); else pass_cnt++;
        total_cnt++; if (hready0 !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", hready0); else pass_cnt++;
        req = 1'b0;
        @(negedge clk); rst0 = 1'b1; #1;
        total_cnt++; if (hready0 !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", hready0); else pass_cnt++;
    endtask

    task automatic test_basic_read;
        logic [31:0] rd; int lat; bit ok;
        push(32'hDEADBEEF); push(32'h00000013);
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'hDEADBEEF) $display("FAIL instr0: got %h want deadbeef", rd); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL latency0: got %0d want 1", lat); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rvalid0 !== 1'b0) $display("FAIL rvalid_one_cycle: got %b want 0", rvalid0); else pass_cnt++;
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h00000013) $display("FAIL instr1: got %h want 00000013", rd); else pass_cnt++;
        xfer(0, 1'b0, 2'd0, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0) $display("FAIL status_empty: got %h want 00000000", rd); else pass_cnt++;
    endtask

    task automatic test_fifo_full;
        logic [31:0] rd; int lat; bit ok;
        logic [31:0] words [4];
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333; words[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) push(words[i]);
        total_cnt++; if (hready0 !== 1'b0) $display("FAIL full_ready: got %b want 0", hready0); else pass_cnt++;
        push(32'h55555555);
        xfer(0, 1'b0, 2'd0, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h00000041) $display("FAIL status_full: got %h want 00000041", rd); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
            total_cnt++; if (!ok || rd !== words[i]) $display("FAIL fifo_order%0d: got %h want %h", i, rd, words[i]); else pass_cnt++;
        end
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0) $display("FAIL underflow_rdata: got %h want 0", rd); else pass_cnt++;
        total_cnt++; if (uf0 !== 1'b1) $display("FAIL underflow_set: got %b want 1", uf0); else pass_cnt++;
        total_cnt++; if (hready0 !== 1'b1) $display("FAIL ready_back: got %b want 1", hready0); else pass_cnt++;
    endtask

    task automatic test_underflow_clear;
        logic [31:0] rd; int lat; bit ok;
        xfer(0, 1'b1, 2'd0, 4'h2, 32'h4, 0, 0, rd, lat, ok);
        total_cnt++; if (uf0 !== 1'b1) $display("FAIL w1c_wrong_be: got %b want 1", uf0); else pass_cnt++;
        xfer(0, 1'b1, 2'd0, 4'h1, 32'h4, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0) $display("FAIL w1c_rdata: got %h want 0", rd); else pass_cnt++;
        total_cnt++; if (uf0 !== 1'b0) $display("FAIL w1c_clear: got %b want 0", uf0); else pass_cnt++;
    endtask

    task automatic test_result;
        logic [31:0] rd; int lat; bit ok; bit seen;
        xfer(0, 1'b1, 2'd2, 4'hF, 32'h12345678, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || hres0 !== 32'h12345678 || hresv0 !== 1'b1)
            $display("FAIL result_write: got %h/%b want 12345678/1", hres0, hresv0); else pass_cnt++;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h8; be = 4'hF; wdata = 32'hCAFEF00D;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (gnt0) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL result_backpressure: got gnt 1 want 0"); else pass_cnt++;
        hack = 1'b1;
        @(posedge clk); #1 hack = 1'b0;
        total_cnt++; if (hresv0 !== 1'b0 || gnt0 !== 1'b1)
            $display("FAIL result_gnt_after_ack: got valid %b gnt %b want 0/1", hresv0, gnt0); else pass_cnt++;
        @(posedge clk); #1 req = 1'b0; we = 1'b0;
        @(negedge clk);
        total_cnt++; if (rvalid0 !== 1'b1 || hres0 !== 32'hCAFEF00D || hresv0 !== 1'b1)
            $display("FAIL result_second: got %b/%h/%b want 1/cafef00d/1", rvalid0, hres0, hresv0); else pass_cnt++;
        ack_pulse();
        ack_pulse();
        total_cnt++; if (hresv0 !== 1'b0 || hres0 !== 32'hCAFEF00D)
            $display("FAIL ack_idle: got %b/%h want 0/cafef00d", hresv0, hres0); else pass_cnt++;
        xfer(0, 1'b1, 2'd2, 4'h1, 32'h000000AB, 0, 0, rd, lat, ok);
        xfer(0, 1'b0, 2'd2, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'hCAFEF0AB) $display("FAIL result_be_read: got %h want cafef0ab", rd); else pass_cnt++;
        ack_pulse();
    endtask

    task automatic test_scratch;
        logic [31:0] rd; int lat; bit ok;
        xfer(0, 1'b1, 2'd3, 4'hF, 32'hAABBCCDD, 0, 0, rd, lat, ok);
        xfer(0, 1'b1, 2'd3, 4'h1, 32'h00000011, 0, 0, rd, lat, ok);
        xfer(0, 1'b0, 2'd3, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'hAABBCC11) $display("FAIL scratch: got %h want aabbcc11", rd); else pass_cnt++;
    endtask

    task automatic test_simul_push_pop;
        logic [31:0] rd; int lat; bit ok;
        push(32'h0A0A0A0A);
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 1, 32'h0B0B0B0B, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0A0A0A0A) $display("FAIL simul_old_head: got %h want 0a0a0a0a", rd); else pass_cnt++;
        xfer(0, 1'b0, 2'd0, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h00000011) $display("FAIL simul_count: got %h want 00000011", rd); else pass_cnt++;
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0B0B0B0B) $display("FAIL simul_pushed: got %h want 0b0b0b0b", rd); else pass_cnt++;
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 1, 32'h0C0C0C0C, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0) $display("FAIL empty_simul_rdata: got %h want 0", rd); else pass_cnt++;
        xfer(0, 1'b0, 2'd0, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h00000015) $display("FAIL empty_simul_status: got %h want 00000015", rd); else pass_cnt++;
        xfer(0, 1'b1, 2'd0, 4'h1, 32'h4, 0, 0, rd, lat, ok);
        xfer(0, 1'b0, 2'd1, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h0C0C0C0C) $display("FAIL empty_simul_stored: got %h want 0c0c0c0c", rd); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int gc [8];
        int g;
        g = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'hC;
        for (int i = 0; i < 8; i++) begin
            #1; if (gnt0) begin gc[g] = cyc; g++; end
            @(negedge clk);
        end
        req = 1'b0;
        total_cnt++; if (g !== 4) $display("FAIL b2b_count: got %0d grants want 4", g); else pass_cnt++;
        total_cnt++; if (g < 2 || gc[1] - gc[0] !== 2) $display("FAIL b2b_spacing: got %0d want 2", (g < 2) ? -1 : gc[1] - gc[0]); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd; int lat; bit ok; bit seen;
        @(negedge clk); rst3 = 1'b1; #1;
        total_cnt++; if (hready3 !== 1'b1) $display("FAIL w3_ready: got %b want 1", hready3); else pass_cnt++;
        push(32'h5A5A5A5A);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF; #1;
        total_cnt++; if (gnt3 !== 1'b1) $display("FAIL w3_gnt: got %b want 1", gnt3); else pass_cnt++;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk); rst3 = 1'b0; #1;
        total_cnt++; if ({gnt3, rvalid3, rdata3, hres3, hresv3, uf3, hready3} !== 69'h0)
            $display("FAIL w3_reset_outputs: got g%b v%b d%h r%h rv%b u%b rdy%b want all 0",
                     gnt3, rvalid3, rdata3, hres3, hresv3, uf3, hready3); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); if (rvalid3) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL w3_no_rvalid: got rvalid 1 want 0"); else pass_cnt++;
        xfer(1, 1'b1, 2'd3, 4'hF, 32'h13572468, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || lat !== 4) $display("FAIL w3_write_latency: got %0d want 4", lat); else pass_cnt++;
        xfer(1, 1'b0, 2'd3, 4'hF, 0, 0, 0, rd, lat, ok);
        total_cnt++; if (!ok || rd !== 32'h13572468 || lat !== 4)
            $display("FAIL w3_read: got %h lat %0d want 13572468 lat 4", rd, lat); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rvalid3 !== 1'b0) $display("FAIL w3_rvalid_one_cycle: got %b want 0", rvalid3); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_fifo_full();
        test_underflow_clear();
        test_result();
        test_scratch();
        test_simul_push_pop();
        test_back_to_back();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
